// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// data-memory wait handling with a timeout, a sticky error flag and a stall counter.
module hazard_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemErr
);

  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;

  logic stall_fetch, stall_decode, stall_exec, stall_mem;
  logic flush_decode, flush_exec;
  logic lw_stall, mem_wait;

  // Memory stage wins over writeback since it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall = ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                    ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign mem_wait = MemReqM & ~MemReadyM;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    stall_exec   = 1'b0;
    stall_mem    = 1'b0;
    flush_decode = 1'b0;
    flush_exec   = 1'b0;
    unique case (state_q)
      RUN, LU_STALL: begin
        state_d = RUN;
        if (mem_wait) begin
          {stall_fetch, stall_decode, stall_exec, stall_mem} = 4'b1111;
          wcnt_d  = '0;
          state_d = MEM_WAIT;
        end else if (PCSrcE) begin
          flush_decode = 1'b1;
          flush_exec   = 1'b1;
        end else if (lw_stall && (state_q == RUN)) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          flush_exec   = 1'b1;
          state_d      = LU_STALL;
        end
      end
      MEM_WAIT: begin
        if (mem_wait && (wcnt_q != WC_MAX)) begin
          {stall_fetch, stall_decode, stall_exec, stall_mem} = 4'b1111;
          wcnt_d = wcnt_q + 1'b1;
        end else begin
          // Leaving the wait: a branch held in Execute is acted on now.
          state_d = RUN;
          if (mem_wait)
            err_d = 1'b1;
          if (PCSrcE) begin
            flush_decode = 1'b1;
            flush_exec   = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign StallF    = rst & stall_fetch;
  assign StallD    = rst & stall_decode;
  assign StallE    = rst & stall_exec;
  assign StallM    = rst & stall_mem;
  assign FlushD    = rst & flush_decode;
  assign FlushE    = rst & flush_exec;
  assign ForwardAE = rst ? fwd_sel(RS1_E, RD_M, RegWriteM, RD_W, RegWriteW) : 2'b00;
  assign ForwardBE = rst ? fwd_sel(RS2_E, RD_M, RegWriteM, RD_W, RegWriteW) : 2'b00;

  assign scnt_d = (StallF && (scnt_q != {CNT_W{1'b1}})) ? scnt_q + 1'b1 : scnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
    end
  end

  assign State      = state_q;
  assign StallCount = scnt_q;
  assign MemErr     = err_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_controller;
  localparam int TO  = 8;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE, State;
  logic [CW-1:0] StallCount;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: mode 0 run, 1 after a load-use bubble, 2 waiting on memory.
  int m_state = 0;
  int m_wait  = 0;
  int m_cnt   = 0;
  int m_err   = 0;

  hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .State(State), .StallCount(StallCount), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input logic [4:0] rs);
    if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2;
    if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 1;
    return 0;
  endfunction

  task automatic model_check();
    int efa, efb, lw, mw, es, efd, efe, nxt, nwait, nerr;
    efa = fwd_exp(RS1_E);
    efb = fwd_exp(RS2_E);
    lw  = (ResultSrcE && RegWriteE && RD_E != 5'd0 &&
           (RD_E == RS1_D || RD_E == RS2_D)) ? 1 : 0;
    mw  = (MemReqM && !MemReadyM) ? 1 : 0;
    es = 0; efd = 0; efe = 0; nxt = 0; nwait = m_wait; nerr = m_err;
    if (m_state == 2) begin
      if (mw == 1 && m_wait < TO) begin
        es = 15; nxt = 2; nwait = m_wait + 1;
      end else begin
        if (mw == 1) nerr = 1;
        if (PCSrcE) begin efd = 1; efe = 1; end
      end
    end else if (mw == 1) begin
      es = 15; nxt = 2; nwait = 0;
    end else if (PCSrcE) begin
      efd = 1; efe = 1;
    end else if (lw == 1 && m_state == 0) begin
      es = 12; efe = 1; nxt = 1;
    end
    if (!rst) begin
      m_state = 0; m_wait = 0; m_cnt = 0; m_err = 0;
      es = 0; efd = 0; efe = 0; efa = 0; efb = 0;
    end
    chk("m_StallF", int'(StallF), (es >> 3) & 1);
    chk("m_StallD", int'(StallD), (es >> 2) & 1);
    chk("m_StallE", int'(StallE), (es >> 1) & 1);
    chk("m_StallM", int'(StallM), es & 1);
    chk("m_FlushD", int'(FlushD), efd);
    chk("m_FlushE", int'(FlushE), efe);
    chk("m_ForwardAE", int'(ForwardAE), efa);
    chk("m_ForwardBE", int'(ForwardBE), efb);
    chk("m_State", int'(State), m_state);
    chk("m_StallCount", int'(StallCount), m_cnt);
    chk("m_MemErr", int'(MemErr), m_err);
    if (rst) begin
      m_state = nxt; m_wait = nwait; m_err = nerr;
      if (es >= 8 && m_cnt < SAT) m_cnt++;
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
  endtask

  task automatic clear();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteE = 0; ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    int found;
    rst = 1'b0;
    clear();
    cyc();
    go(); cyc();
    chk("rst_State", int'(State), 0);
    chk("rst_StallCount", int'(StallCount), 0);
    go(); rst = 1'b1; cyc();

    // Load-use on x5
    go(); RS1_D = 5; RD_E = 5; ResultSrcE = 1; RegWriteE = 1; cyc();
    chk("lu_stalls", int'({StallF, StallD, StallE, StallM}), 12);
    chk("lu_FlushE", int'(FlushE), 1);
    go(); clear(); cyc();
    chk("lu_State1", int'(State), 1);
    chk("lu_StallF_after", int'(StallF), 0);
    go(); cyc();
    chk("lu_State0", int'(State), 0);
    chk("lu_StallCount", int'(StallCount), 1);

    // Forwarding priority and x0
    go(); RD_M = 3; RegWriteM = 1; RD_W = 3; RegWriteW = 1; RS1_E = 3; cyc();
    chk("fwd_mem", int'(ForwardAE), 2);
    go(); RegWriteM = 0; cyc();
    chk("fwd_wb", int'(ForwardAE), 1);
    go(); RD_W = 0; cyc();
    chk("fwd_rf", int'(ForwardAE), 0);
    go(); clear(); RegWriteM = 1; RegWriteW = 1; ResultSrcE = 1; RegWriteE = 1; cyc();
    chk("x0_fwdB", int'(ForwardBE), 0);
    chk("x0_nostall", int'(StallF), 0);

    // Memory wait for four cycles, then ready
    go(); clear(); MemReqM = 1; cyc();
    chk("mw_entry_stalls", int'({StallF, StallD, StallE, StallM}), 15);
    chk("mw_entry_State", int'(State), 0);
    for (int i = 1; i < 4; i++) begin
      go(); cyc();
      chk("mw_hold_stalls", int'({StallF, StallD, StallE, StallM}), 15);
    end
    go(); MemReadyM = 1; cyc();
    chk("mw_ready_stalls", int'({StallF, StallD, StallE, StallM}), 0);
    chk("mw_ready_State", int'(State), 2);
    go(); clear(); cyc();
    chk("mw_back_State", int'(State), 0);

    // Branch against load-use, then branch against memory wait
    go(); PCSrcE = 1; ResultSrcE = 1; RegWriteE = 1; RD_E = 7; RS2_D = 7; cyc();
    chk("br_lu_flush", int'({FlushD, FlushE}), 3);
    chk("br_lu_StallF", int'(StallF), 0);
    go(); MemReqM = 1; cyc();
    chk("br_mw_stalls", int'({StallF, StallD, StallE, StallM}), 15);
    chk("br_mw_flush", int'({FlushD, FlushE}), 0);
    go(); cyc();
    chk("br_mw_hold_flush", int'({FlushD, FlushE}), 0);
    go(); MemReadyM = 1; cyc();
    go(); clear(); cyc();

    // Timeout after TO wait cycles
    go(); MemReqM = 1; cyc();
    for (int i = 1; i < 10; i++) begin go(); cyc(); end
    chk("to_StallF", int'(StallF), 0);
    chk("to_MemErr_pre", int'(MemErr), 0);
    go(); cyc();
    chk("to_State", int'(State), 0);
    chk("to_MemErr", int'(MemErr), 1);

    // Saturation of the stall counter under a sustained wait
    for (int i = 0; i < 100; i++) begin go(); cyc(); end
    chk("sat_StallCount", int'(StallCount), SAT);
    chk("sticky_MemErr", int'(MemErr), 1);

    // Reset in the middle of a memory wait
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      go(); cyc();
      if (State == 2'b10) found = 1;
    end
    chk("find_memwait", found, 1);
    #2; RD_M = 3; RegWriteM = 1; RS1_E = 3; rst = 1'b0;
    #1;
    chk("arst_State", int'(State), 0);
    chk("arst_stalls", int'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 0);
    chk("arst_fwd", int'(ForwardAE), 0);
    chk("arst_cnt_err", int'({StallCount, MemErr}), 0);
    go(); cyc();
    go(); clear(); rst = 1'b1; cyc();
    chk("arst_release", int'({State, StallF}), 0);

    // Reset in LU_STALL
    go(); RS2_D = 9; RD_E = 9; ResultSrcE = 1; RegWriteE = 1; cyc();
    go(); clear(); cyc();
    chk("lurst_pre", int'(State), 1);
    #2; rst = 1'b0;
    #1;
    chk("lurst_State", int'(State), 0);
    go(); cyc();
    go(); rst = 1'b1; cyc();
    chk("lurst_release", int'({State, StallF}), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      go();
      RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
      RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
      RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
      RD_W  = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1)); ResultSrcE = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1)); RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 7) == 0);
      MemReqM    = (i < 300 && State == 2'b10) ? 1'b1 : ($urandom_range(0, 2) == 0);
      MemReadyM  = (i < 300) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 60) != 0);
      cyc();
    end

    go(); clear(); rst = 1'b1; cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
